// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type for the fabric arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        INCR  = 2'd3
    } arb_state_t;

    // Beats in a burst; 0 marks undefined-length INCR.
    function automatic logic [4:0] burst_len(hburst_t b);
        logic [4:0] len;
        case (b)
            HB_SINGLE:           len = 5'd1;
            HB_INCR:             len = 5'd0;
            HB_WRAP4, HB_INCR4:  len = 5'd4;
            HB_WRAP8, HB_INCR8:  len = 5'd8;
            default:             len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping.
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [3:0]             ptr,
    output logic [3:0]             winner,
    output logic                   any_req
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    logic [4:0]               sum;

    assign any_req = |req;

    // Rotate so bit 0 is the pointer slot, then take the lowest set offset.
    always_comb begin
        dbl    = {req, req};
        rot    = NUM_MASTERS'(dbl >> ptr);
        winner = 4'(DEFAULT_MASTER);
        sum    = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = 5'({1'b0, ptr}) + 5'(i);
                if (sum >= 5'(NUM_MASTERS)) begin
                    sum = sum - 5'(NUM_MASTERS);
                end
                winner = sum[3:0];
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: one-hot grant, address- and data-phase owner indices.
// Grant moves only on accepted edges and never inside a fixed-length burst.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_INCR       = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] mHBUSREQ,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] mHGRANT,
    output logic [3:0]             HMASTER,
    output logic [3:0]             HMASTER_D
);

    localparam int unsigned CNT_MAX = (MAX_INCR > 15) ? MAX_INCR : 15;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]       MAX_CNT   = CNT_W'(MAX_INCR);
    localparam logic [NUM_MASTERS-1:0] ONE       = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE << DEFAULT_MASTER;
    localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [3:0]             PTR_RST   = 4'((DEFAULT_MASTER + 1) % NUM_MASTERS);
    localparam logic [3:0]             LAST_IDX  = 4'(NUM_MASTERS - 1);

    arb_state_t             state;
    arb_state_t             nxt_state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       nxt_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [3:0]             ptr;
    logic [3:0]             ptr_after;
    logic [3:0]             owner;
    logic [3:0]             hmaster;
    logic [3:0]             hmaster_d;
    logic [NUM_MASTERS-1:0] grant;
    logic [3:0]             pick;
    logic                   any_req;
    logic                   owner_req;
    logic                   others_req;
    logic                   rearb;
    htrans_t                trans;
    hburst_t                burst;

    ahb_rr_pick #(
        .NUM_MASTERS    (NUM_MASTERS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_pick (
        .req     (mHBUSREQ),
        .ptr     (ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    assign trans      = htrans_t'(HTRANS);
    assign burst      = hburst_t'(HBURST);
    assign owner_req  = |(mHBUSREQ & grant);
    assign others_req = |(mHBUSREQ & ~grant);
    assign cnt_inc    = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;
    assign ptr_after  = (pick == LAST_IDX) ? 4'd0 : pick + 4'd1;

    // Decide, for an accepted edge, whether to re-arbitrate or advance the burst.
    always_comb begin
        rearb     = 1'b0;
        nxt_state = state;
        nxt_cnt   = cnt;
        if (HRESP == HRESP_ERROR) begin
            rearb = 1'b1;
        end else begin
            unique case (state)
                PARK: rearb = 1'b1;
                GRANT: begin
                    if (trans == NONSEQ) begin
                        if (burst == HB_SINGLE) begin
                            rearb = 1'b1;
                        end else if (burst == HB_INCR) begin
                            nxt_state = INCR;
                            nxt_cnt   = CNT_W'(1);
                        end else begin
                            nxt_state = BURST;
                            nxt_cnt   = CNT_W'(burst_len(burst) - 5'd1);
                        end
                    end else if (trans == IDLE || !owner_req) begin
                        rearb = 1'b1;
                    end
                end
                BURST: begin
                    if (trans == SEQ) begin
                        if (cnt == CNT_W'(1)) begin
                            rearb = 1'b1;
                        end else begin
                            nxt_cnt = cnt - 1'b1;
                        end
                    end
                end
                INCR: begin
                    if (trans == IDLE || !owner_req) begin
                        rearb = 1'b1;
                    end else if (trans == SEQ) begin
                        nxt_cnt = cnt_inc;
                        // Cap long INCR bursts only when someone else is waiting.
                        if (cnt_inc >= MAX_CNT && others_req) begin
                            rearb = 1'b1;
                        end
                    end
                end
                default: rearb = 1'b1;
            endcase
        end
    end

    // Arbiter state, grant and owner pipeline; everything advances only on accept.
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state     <= PARK;
            cnt       <= '0;
            ptr       <= PTR_RST;
            owner     <= DEF_IDX;
            grant     <= DEF_GRANT;
            hmaster   <= DEF_IDX;
            hmaster_d <= DEF_IDX;
        end else if (HREADY) begin
            hmaster   <= owner;
            hmaster_d <= hmaster;
            if (rearb) begin
                owner <= pick;
                grant <= ONE << pick;
                cnt   <= '0;
                if (any_req) begin
                    state <= GRANT;
                    ptr   <= ptr_after;
                end else begin
                    state <= PARK;
                end
            end else begin
                state <= nxt_state;
                cnt   <= nxt_cnt;
            end
        end
    end

    assign mHGRANT   = grant;
    assign HMASTER   = hmaster;
    assign HMASTER_D = hmaster_d;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: directed scenarios plus random traffic,
// each edge predicted by a behavioural model and compared by a monitor.
module tb_ahb_rr_arbiter;
    import ahb_pkg::*;

    localparam int N        = 4;
    localparam int DEF_M    = 0;
    localparam int MAX_BEAT = 16;

    localparam int M_PARK  = 0;
    localparam int M_OWNED = 1;
    localparam int M_FIXED = 2;
    localparam int M_INCR  = 3;

    logic         HCLK;
    logic         HRESET;
    logic [N-1:0] mHBUSREQ;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [N-1:0] mHGRANT;
    logic [3:0]   HMASTER;
    logic [3:0]   HMASTER_D;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF_M),
        .MAX_INCR       (MAX_BEAT)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .mHBUSREQ  (mHBUSREQ),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .mHGRANT   (mHGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] hm;
        logic [3:0] hmd;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model state: who owns the bus and what they are doing.
    int m_owner, m_ptr, m_mode, m_beats, m_hm, m_hmd;
    int len_tab[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic exp_t model_step();
        bit   rearb;
        bit   found;
        int   m;
        exp_t e;
        if (!HRESET) begin
            m_owner = DEF_M;
            m_ptr   = (DEF_M + 1) % N;
            m_mode  = M_PARK;
            m_beats = 0;
            m_hm    = DEF_M;
            m_hmd   = DEF_M;
        end else if (HREADY) begin
            m_hmd = m_hm;
            m_hm  = m_owner;
            rearb = 0;
            if (HRESP == HRESP_ERROR) begin
                rearb = 1;
            end else if (m_mode == M_PARK) begin
                rearb = 1;
            end else if (m_mode == M_OWNED) begin
                if (HTRANS == 2'd2) begin
                    if (HBURST == 3'd0) begin
                        rearb = 1;
                    end else if (HBURST == 3'd1) begin
                        m_mode  = M_INCR;
                        m_beats = 1;
                    end else begin
                        m_mode  = M_FIXED;
                        m_beats = len_tab[HBURST] - 1;   // SEQ beats still owed
                    end
                end else if (HTRANS == 2'd0 || !mHBUSREQ[m_owner]) begin
                    rearb = 1;
                end
            end else if (m_mode == M_FIXED) begin
                if (HTRANS == 2'd3) begin
                    m_beats = m_beats - 1;
                    if (m_beats == 0) rearb = 1;
                end
            end else begin
                if (HTRANS == 2'd0 || !mHBUSREQ[m_owner]) begin
                    rearb = 1;
                end else if (HTRANS == 2'd3) begin
                    m_beats = m_beats + 1;
                    if (m_beats >= MAX_BEAT && (mHBUSREQ & ~(4'b1 << m_owner)) != 0) rearb = 1;
                end
            end
            if (rearb) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    m = (m_ptr + k) % N;
                    if (!found && mHBUSREQ[m]) begin
                        found   = 1;
                        m_owner = m;
                    end
                end
                if (found) begin
                    m_ptr  = (m_owner + 1) % N;
                    m_mode = M_OWNED;
                end else begin
                    m_owner = DEF_M;
                    m_mode  = M_PARK;
                end
                m_beats = 0;
            end
        end
        e.grant = 4'b1 << m_owner;
        e.hm    = 4'(m_hm);
        e.hmd   = 4'(m_hmd);
        return e;
    endfunction

    // Apply one cycle of inputs; expected post-edge outputs go to the scoreboard.
    task automatic tick(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [1:0] rsp, input logic rst_n);
        exp_t e;
        mHBUSREQ = req;
        HTRANS   = tr;
        HBURST   = bu;
        HREADY   = rdy;
        HRESP    = rsp;
        HRESET   = rst_n;
        e = model_step();
        @(posedge HCLK);
        sb.push_back(e);
        #1;
    endtask

    function automatic void dchk(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic do_reset();
        tick(4'b0000, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b0);
        tick(4'b0000, IDLE, HB_SINGLE, 1'b0, HRESP_OKAY, 1'b0);
    endtask

    // Monitor: one scoreboard entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (mHGRANT !== e.grant || HMASTER !== e.hm || HMASTER_D !== e.hmd) begin
                    n_fail++;
                    $display("FAIL model cycle %0d: grant=%b hm=%0d hmd=%0d, expected %b %0d %0d",
                             cyc, mHGRANT, HMASTER, HMASTER_D, e.grant, e.hm, e.hmd);
                end
            end
        end
    end

    initial begin
        int order[5] = '{1, 2, 3, 1, 2};
        mHBUSREQ = '0;
        HTRANS   = IDLE;
        HBURST   = HB_SINGLE;
        HREADY   = 1'b1;
        HRESP    = HRESP_OKAY;
        HRESET   = 1'b0;

        // Reset with nobody requesting parks the default master.
        do_reset();
        dchk("reset_grant", 32'(mHGRANT), 32'h1);
        dchk("reset_hmaster", 32'(HMASTER), 32'h0);
        dchk("reset_hmaster_d", 32'(HMASTER_D), 32'h0);

        // Three masters with SINGLE transfers rotate 1,2,3,1,2.
        for (int i = 0; i < 5; i++) begin
            tick(4'b1110, NONSEQ, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
            dchk($sformatf("rr_single_%0d", i), 32'(mHGRANT), 32'(4'b1 << order[i]));
        end

        // M2 INCR8 with stalls and a BUSY beat; M0 waits until the 8th beat.
        do_reset();
        tick(4'b0101, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        dchk("incr8_grant_m2", 32'(mHGRANT), 32'h4);
        tick(4'b0101, NONSEQ, HB_INCR8, 1'b1, HRESP_OKAY, 1'b1);
        for (int b = 2; b <= 8; b++) begin
            if (b == 3 || b == 6) begin
                repeat (2) tick(4'b0101, SEQ, HB_INCR8, 1'b0, HRESP_OKAY, 1'b1);
            end
            if (b == 5) tick(4'b0101, BUSY, HB_INCR8, 1'b1, HRESP_OKAY, 1'b1);
            tick(4'b0101, SEQ, HB_INCR8, 1'b1, HRESP_OKAY, 1'b1);
            dchk($sformatf("incr8_beat_%0d", b), 32'(mHGRANT), (b == 8) ? 32'h1 : 32'h4);
        end

        // M1 undefined INCR capped at 16 beats while M3 waits.
        do_reset();
        tick(4'b1010, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b1010, NONSEQ, HB_INCR, 1'b1, HRESP_OKAY, 1'b1);
        for (int b = 2; b <= 16; b++) begin
            tick(4'b1010, SEQ, HB_INCR, 1'b1, HRESP_OKAY, 1'b1);
            if (b >= 14) dchk($sformatf("incr_cap_%0d", b), 32'(mHGRANT), (b == 16) ? 32'h8 : 32'h2);
        end

        // With nobody else waiting, the INCR runs on for 40 beats.
        do_reset();
        tick(4'b0010, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0010, NONSEQ, HB_INCR, 1'b1, HRESP_OKAY, 1'b1);
        for (int b = 2; b <= 40; b++) tick(4'b0010, SEQ, HB_INCR, 1'b1, HRESP_OKAY, 1'b1);
        dchk("incr_40_beats", 32'(mHGRANT), 32'h2);

        // M0 WRAP4 aborted by an ERROR on beat 2.
        do_reset();
        tick(4'b0001, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0011, NONSEQ, HB_WRAP4, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0011, SEQ, HB_WRAP4, 1'b0, HRESP_ERROR, 1'b1);
        dchk("err_wait_grant", 32'(mHGRANT), 32'h1);
        tick(4'b0011, SEQ, HB_WRAP4, 1'b1, HRESP_ERROR, 1'b1);
        dchk("err_abort_grant", 32'(mHGRANT), 32'h2);
        dchk("err_abort_hmaster", 32'(HMASTER), 32'h0);
        tick(4'b0011, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        dchk("err_next_hmaster", 32'(HMASTER), 32'h1);
        dchk("err_next_hmaster_d", 32'(HMASTER_D), 32'h0);

        // Sole requester M3 keeps the bus, then releases to the default master.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(4'b1000, NONSEQ, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
            dchk($sformatf("sole_m3_%0d", i), 32'(mHGRANT), 32'h8);
        end
        tick(4'b0000, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        dchk("sole_release", 32'(mHGRANT), 32'h1);

        // Reset in the middle of an INCR4 burst.
        tick(4'b0010, IDLE, HB_SINGLE, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0010, NONSEQ, HB_INCR4, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0010, SEQ, HB_INCR4, 1'b1, HRESP_OKAY, 1'b1);
        tick(4'b0010, SEQ, HB_INCR4, 1'b0, HRESP_OKAY, 1'b0);
        dchk("midburst_rst_grant", 32'(mHGRANT), 32'h1);
        dchk("midburst_rst_hmaster", 32'(HMASTER), 32'h0);
        dchk("midburst_rst_hmaster_d", 32'(HMASTER_D), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            tick(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0) ? HRESP_ERROR : HRESP_OKAY,
                 ($urandom_range(0, 149) != 0));
        end

        repeat (2) @(negedge HCLK);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
AHB bus arbiter for the NN calculator SoC fabric. It takes mHBUSREQ from up to NUM_MASTERS masters and drives one-hot mHGRANT plus the address-phase and data-phase owner indices. The fabric uses these indices to steer the HADDR/HTRANS/HWDATA muxes and route HRDATA/HRESP. Grant changes only at legal AHB boundaries: fixed-length bursts are never split, and undefined-length INCR bursts are capped at MAX_INCR beats when other masters are waiting.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, master parked on the bus when nobody requests
MAX_INCR, 16, accepted beats after which an INCR burst is re-arbitrated if another master requests

Ports:
HCLK  input  1  bus clock
HRESET  input  1  synchronous, active-low reset
mHBUSREQ  input  NUM_MASTERS  per-master bus request
HTRANS  input  2  HTRANS of current address-phase owner (muxed by fabric)
HBURST  input  3  HBURST of current address-phase owner
HREADY  input  1  global HREADY, transfer-accepted qualifier
HRESP  input  2  slave response, 2'b01 = ERROR
mHGRANT  output  NUM_MASTERS  one-hot grant
HMASTER  output  4  address-phase owner index
HMASTER_D  output  4  data-phase owner index (HWDATA/HRDATA steering)

Behaviour:
- Reset: all state updates only on rising HCLK with HRESET==0 (synchronous), whether or not HREADY is high.
  - mHGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_D = DEFAULT_MASTER.
  - State = PARK; beat counter = 0; RR pointer = DEFAULT_MASTER+1 mod N.
- Accept: "accept" means an edge with HREADY==1. HMASTER <= index(mHGRANT) on accept; HMASTER_D <= HMASTER on accept. Both hold while HREADY==0.
- Round-robin pick: combinational. Search mHBUSREQ starting at the RR pointer and wrapping. No request selects DEFAULT_MASTER. After a grant, the pointer becomes winner+1 mod N.
- States:
  - PARK: default master granted, no requests.
    - Any request on accept -> GRANT to the pick, mHGRANT updated at that edge.
  - GRANT: owner granted, no fixed burst in flight.
    - On accept with HTRANS==NONSEQ and HBURST in {2..7}: load counter = len-1 (len 4/8/16), go to BURST, grant frozen.
    - HBURST==INCR(1): load INCR counter = 1, go to INCR.
    - HBURST==SINGLE: stay in GRANT and re-arbitrate at this edge.
    - On accept with HTRANS==IDLE or owner's mHBUSREQ==0: re-arbitrate. Go to PARK if no requests, else GRANT.
  - BURST: on accept with HTRANS==SEQ, counter--. BUSY and accepts with HREADY==0 do not count.
    - When the accepted SEQ has counter==1 (last beat), re-arbitrate at that edge and go to GRANT or PARK.
  - INCR: on accept with SEQ, counter++.
    - Re-arbitrate when HTRANS==IDLE or owner request drops.
    - Also re-arbitrate when counter>=MAX_INCR and another master requests. The new owner restarts with NONSEQ.
  - Any state: accept with HRESP==ERROR aborts the burst. Counter cleared, re-arbitrate, go to GRANT or PARK.
- Latency: the grant changes on the edge of the owner's last accepted address phase. The new master drives NONSEQ earliest one cycle later (one handover cycle, owner mux parked on IDLE).
- Re-arbitration may re-pick the same master (sole requester keeps the bus, no dead cycle).
- Simultaneous requests: the RR pointer decides; the current owner ranks last.
- mHGRANT is registered and always exactly one-hot.
- HMASTER width is fixed at 4; unused upper values never occur.
- Reset during a burst: immediate return to PARK; the burst is abandoned and the bench expects no completion.

Decomposition:
- Package ahb_pkg:
  - htrans_t enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hburst_t encodings and hresp codes.
  - arb_state_t enum: PARK, GRANT, BURST, INCR.
  - function burst_len(hburst_t) returns 1/0/4/8/16.
- Sub-module ahb_rr_pick: combinational rotate-priority encoder with inputs req, ptr and outputs winner index, any_req.

Test Plan:
- Reset, no requests -> mHGRANT=4'b0001, HMASTER=0, HMASTER_D=0, state PARK. Assert HRESET low mid-INCR4 -> same values on next edge.
- M1,M2,M3 request continuously with SINGLE transfers, HREADY=1 -> grant order 1,2,3,1,2 (one grant per accepted transfer), pointer wraps correctly.
- M2 INCR8 burst while M0 requests, HREADY stalls of 2 cycles on beats 3 and 6, one BUSY beat -> mHGRANT stays 4'b0100 until the 8th accepted beat, then switches to 4'b0001 at that edge.
- M1 INCR burst, MAX_INCR=16, M3 requesting -> grant moves to M3 exactly at the 16th accepted beat. With M3 not requesting, M1 keeps the grant for 40 beats.
- M0 WRAP4 burst, ERROR response on beat 2 with HREADY=1 -> burst aborted, re-arbitration at that edge, HMASTER_D follows HMASTER with one accepted-edge delay.
- Only M3 requests, SINGLE transfers back-to-back -> mHGRANT held at 4'b1000 with no handover cycle. M3 drops request -> grant returns to DEFAULT_MASTER, state PARK.
